// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram_like two-requester arbiter: FSM states,
// owner codes, transfer sizes and the forwarded command bundle.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sl_cmd_t;

  // One-hot steering vector {data, inst} for an owner code.
  function automatic logic [1:0] own2gnt(input logic own);
    return (own == OWN_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like port bundle. The requester side is the master; the memory
// side (or an arbiter input) is the slave.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_arb_pick2.sv
// Two-way picker: bit0 = inst, bit1 = data. On a tie the data side wins
// when i_prio is set, otherwise the side that was not granted last.
module arb_pick2
  import sram_like_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_prio || (i_last == OWN_INST)) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram_like port between the IF-stage (inst) and MEM-stage (data)
// requesters, one transaction outstanding, with inst flush support.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_cancel,
  sram_like_arbiter_if.slave         inst_if,
  sram_like_arbiter_if.slave         data_if,
  sram_like_arbiter_if.master        m_if
);

  arb_state_e r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last,  w_last_nxt;
  logic       r_drop,  w_drop_nxt;

  logic [1:0] w_req, w_gnt, w_aok, w_dok;
  logic       w_sel, w_mreq, w_own_req, w_drop_now;
  sl_cmd_t    w_inst_cmd, w_data_cmd, w_fwd;

  assign w_req = {data_if.req, inst_if.req};

  assign w_inst_cmd = '{wr: inst_if.wr, size: inst_if.size,
                        addr: inst_if.addr, wdata: inst_if.wdata};
  assign w_data_cmd = '{wr: data_if.wr, size: data_if.size,
                        addr: data_if.addr, wdata: data_if.wdata};

  arb_pick2 u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .i_prio (DATA_PRIORITY),
    .o_gnt  (w_gnt)
  );

  assign w_own_req  = (r_owner == OWN_DATA) ? data_if.req : inst_if.req;
  // A flush only matters once inst owns the port; in IDLE it is ignored.
  assign w_drop_now = r_drop | (inst_cancel & (r_owner == OWN_INST));

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_drop_nxt  = r_drop;
    w_sel       = r_owner;
    w_mreq      = 1'b0;
    w_aok       = 2'b00;
    w_dok       = 2'b00;
    unique case (r_state)
      ARB_IDLE: begin
        if (|w_req) begin
          w_sel       = w_gnt[1] ? OWN_DATA : OWN_INST;
          w_mreq      = 1'b1;
          w_owner_nxt = w_sel;
          if (m_if.addr_ok) begin
            w_aok       = own2gnt(w_sel);
            w_last_nxt  = w_sel;
            w_state_nxt = ARB_WAIT;
          end else begin
            w_state_nxt = ARB_REQ;
          end
        end
      end
      ARB_REQ: begin
        w_drop_nxt = w_drop_now;
        // A cancelled request is kept on the bus so the slave sees a clean
        // handshake; its data is swallowed later.
        if (!w_own_req && !w_drop_now) begin
          w_state_nxt = ARB_IDLE;
          w_drop_nxt  = 1'b0;
        end else begin
          w_mreq = 1'b1;
          if (m_if.addr_ok) begin
            w_aok       = own2gnt(r_owner) & w_req;
            w_last_nxt  = r_owner;
            w_state_nxt = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        w_drop_nxt = w_drop_now;
        if (m_if.data_ok) begin
          if (!w_drop_now) w_dok = own2gnt(r_owner);
          w_state_nxt = ARB_IDLE;
          w_drop_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_INST;
      r_last  <= OWN_INST;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign w_fwd = (w_sel == OWN_DATA) ? w_data_cmd : w_inst_cmd;

  // Everything is held at zero while reset is high, including mid-transaction.
  assign m_if.req   = w_mreq & ~reset;
  assign m_if.wr    = w_fwd.wr & ~reset;
  assign m_if.size  = reset ? 2'b00 : w_fwd.size;
  assign m_if.addr  = reset ? 32'd0 : w_fwd.addr;
  assign m_if.wdata = reset ? 32'd0 : w_fwd.wdata;

  assign inst_if.addr_ok = w_aok[0] & ~reset;
  assign data_if.addr_ok = w_aok[1] & ~reset;
  assign inst_if.data_ok = w_dok[0] & ~reset;
  assign data_if.data_ok = w_dok[1] & ~reset;
  assign inst_if.rdata   = reset ? 32'd0 : m_if.rdata;
  assign data_if.rdata   = reset ? 32'd0 : m_if.rdata;

endmodule
